// File: rtl/fft_reorder_buffer.sv
// Ping-pong frame buffer feeding the radix-2 FFT: frames arrive in natural order
// and leave in bit-reversed (or natural, when bypassed) order, one sample per clock.
module fft_reorder_buffer #(
   parameter int SAMPLES = 8,
   parameter int WIDTH   = 16,
   localparam int IW     = $clog2(SAMPLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reverse_en,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [IW-1:0]    out_index
);

   localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);

   logic [WIDTH-1:0] mem [2][SAMPLES];
   logic [1:0]       full;
   logic [1:0]       mode;
   logic             wr_bank;
   logic             rd_bank;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd_idx;
   logic [IW-1:0]    rev_idx;
   logic [IW-1:0]    rd_addr;
   logic             wr_fire;
   logic             rd_fire;

   genvar gi;
   generate
      for (gi = 0; gi < IW; gi++) begin : g_bitrev
         assign rev_idx[gi] = rd_idx[IW-1-gi];
      end
   endgenerate

   assign in_ready  = !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign wr_fire   = in_valid && in_ready;
   assign rd_fire   = out_valid && out_ready;
   assign rd_addr   = mode[rd_bank] ? rev_idx : rd_idx;
   assign out_data  = mem[rd_bank][rd_addr];
   assign out_index = rd_addr;
   assign out_last  = out_valid && (rd_idx == LAST_IDX);

   // Sample storage has no reset; flush discards the colliding write.
   always_ff @(posedge clk) begin
      if (wr_fire && !flush) begin
         mem[wr_bank][wr_idx] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full    <= '0;
         mode    <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_idx  <= '0;
         rd_idx  <= '0;
      end else if (flush) begin
         full    <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_idx  <= '0;
         rd_idx  <= '0;
      end else begin
         // Write and read always target different banks, so the two full-bit updates never collide.
         if (wr_fire) begin
            if (wr_idx == '0) begin
               mode[wr_bank] <= reverse_en;
            end
            if (wr_idx == LAST_IDX) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= !wr_bank;
               wr_idx        <= '0;
            end else begin
               wr_idx <= wr_idx + IW'(1);
            end
         end
         if (rd_fire) begin
            if (rd_idx == LAST_IDX) begin
               full[rd_bank] <= 1'b0;
               rd_bank       <= !rd_bank;
               rd_idx        <= '0;
            end else begin
               rd_idx <= rd_idx + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Directed bench for fft_reorder_buffer (SAMPLES=8, WIDTH=8): expected output
// order comes from a hand-written bit-reversal table and a scoreboard queue.
module tb_fft_reorder_buffer;

   localparam int SAMPLES = 8;
   localparam int WIDTH   = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             reverse_en;
   logic             flush;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [2:0]       out_index;

   fft_reorder_buffer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reverse_en (reverse_en),
      .flush      (flush),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .out_index  (out_index)
   );

   always #5 clk = !clk;

   typedef struct packed {
      logic       last;
      logic [2:0] idx;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_xfer_cyc = 0;
   int   n_acc    = 0;
   int   br[8]    = '{0, 4, 2, 6, 1, 5, 3, 7};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard: every output transfer is compared against the head of exp_q.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         $display("out xfer: idx=%0d data=0x%02h last=%0d", out_index, out_data, out_last);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_out", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("out_data", 32'(out_data), 32'(e.data));
            check_eq("out_index", 32'(out_index), 32'(e.idx));
            check_eq("out_last", 32'(out_last), 32'(e.last));
         end
         last_xfer_cyc = cyc;
      end
   end

   task automatic push_frame(input logic [7:0] base, input bit rev);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.idx  = rev ? 3'(br[i]) : 3'(i);
         e.data = base + 8'(e.idx);
         e.last = (i == 7);
         exp_q.push_back(e);
      end
   endtask

   // Holds in_valid with d until accepted; leaves in_valid high for back-to-back use.
   task automatic send(input logic [7:0] d, output int stalls);
      bit acc;
      stalls   = 0;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (!acc) stalls++;
      end while (!acc && stalls < 300);
      if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
      n_acc++;
   endtask

   task automatic send_frame(input logic [7:0] base, output int stalls);
      int s;
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         send(base + 8'(i), s);
         stalls += s;
      end
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check_eq({tag, "_idle"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, st;
      int start_cyc;
      int base_acc;

      rst_n      = 1'b0;
      reverse_en = 1'b1;
      flush      = 1'b0;
      in_data    = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_last", 32'(out_last), 32'd0);
      check_eq("rst_out_index", 32'(out_index), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Bit-reversed frame and first-output latency
      push_frame(8'h00, 1'b1);
      send_frame(8'h00, st);
      check_eq("lat_out_valid", 32'(out_valid), 32'd1);
      check_eq("lat_out_data", 32'(out_data), 32'd0);
      check_eq("lat_out_index", 32'(out_index), 32'd0);
      in_valid = 1'b0;
      wait_drain("drain_rev");

      // Natural-order bypass
      reverse_en = 1'b0;
      push_frame(8'h10, 1'b0);
      send_frame(8'h10, st);
      in_valid = 1'b0;
      wait_drain("drain_nat");

      // Three continuous frames: no input stalls, no output bubbles
      reverse_en = 1'b1;
      push_frame(8'h00, 1'b1);
      push_frame(8'h08, 1'b1);
      push_frame(8'h10, 1'b1);
      s = 0;
      for (int f = 0; f < 3; f++) begin
         send_frame(8'(f * 8), st);
         s += st;
         if (f == 0) start_cyc = cyc;
      end
      in_valid = 1'b0;
      check_eq("cont_stalls", 32'(s), 32'd0);
      wait_drain("drain_cont");
      check_eq("cont_span", 32'(last_xfer_cyc - start_cyc), 32'd23);

      // Back-pressure: 24 samples with out_ready low
      out_ready = 1'b0;
      push_frame(8'h20, 1'b1);
      push_frame(8'h28, 1'b1);
      push_frame(8'h30, 1'b1);
      base_acc = n_acc;
      fork
         begin
            int s16;
            s16 = 0;
            for (int i = 0; i < 24; i++) begin
               send(8'h20 + 8'(i), st);
               if (i < 16) s16 += st;
            end
            in_valid = 1'b0;
            check_eq("bp_first16_stalls", 32'(s16), 32'd0);
         end
         begin
            int n;
            n = 0;
            while (n_acc < base_acc + 16 && n < 100) begin
               @(negedge clk);
               n++;
            end
            repeat (2) @(negedge clk);
            check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_data", 32'(out_data), 32'h20);
            repeat (3) @(negedge clk);
            check_eq("bp_hold_data2", 32'(out_data), 32'h20);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_last && n < 50);
            check_eq("bp_ready_at_last", 32'(in_ready), 32'd0);
            @(negedge clk);
            check_eq("bp_ready_after_last", 32'(in_ready), 32'd1);
         end
      join
      wait_drain("drain_bp");

      // reverse_en change mid-frame only affects the next frame
      reverse_en = 1'b1;
      push_frame(8'hA0, 1'b1);
      push_frame(8'hA8, 1'b0);
      for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), st);
      reverse_en = 1'b0;
      for (int i = 3; i < 8; i++) send(8'hA0 + 8'(i), st);
      send_frame(8'hA8, st);
      in_valid = 1'b0;
      wait_drain("drain_toggle");

      // Asynchronous reset mid-frame
      reverse_en = 1'b1;
      for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), st);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_out_last", 32'(out_last), 32'd0);
      check_eq("mid_rst_out_index", 32'(out_index), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_frame(8'h70, 1'b1);
      send_frame(8'h70, st);
      in_valid = 1'b0;
      wait_drain("drain_rst");

      // Flush mid-frame, with a colliding write that must be discarded
      for (int i = 0; i < 5; i++) send(8'h80 + 8'(i), st);
      in_data = 8'hEE;
      flush   = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check_eq("flush_in_ready", 32'(in_ready), 32'd1);
      check_eq("flush_out_valid", 32'(out_valid), 32'd0);
      check_eq("flush_out_index", 32'(out_index), 32'd0);
      push_frame(8'h90, 1'b1);
      send_frame(8'h90, st);
      in_valid = 1'b0;
      wait_drain("drain_flush");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
